// File: rtl/uart_wb_master.sv
// Wishbone classic master: one bus cycle per 34-bit UART command, response streamed to the transmitter.
// Optional bus timeout enabled by defining UART_WB_TIMEOUT_EN.
module uart_wb_master #(
  parameter bit AUTO_INC = 1'b1
`ifdef UART_WB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_stb,
  input  logic [33:0] i_cmd_word,
  output logic        o_cmd_busy,
  output logic        o_overrun,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_busy
);

  typedef enum logic [2:0] {IDLE, BUS, TX_LOAD, TX_GAP, TX_WAIT} state_t;

  state_t      state;
  logic [1:0]  opcode;
  logic [31:0] payload;
  logic [31:0] addr;
  logic [39:0] frame;
  logic [2:0]  frame_len;
  logic [2:0]  byte_cnt;
`ifdef UART_WB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
`endif

  assign opcode     = i_cmd_word[33:32];
  assign payload    = i_cmd_word[31:0];
  assign o_wb_addr  = addr;
  assign o_cmd_busy = (state != IDLE);

  // The frame is left-aligned so the next byte to send is always frame[39:32].
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      o_overrun  <= 1'b0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_data  <= 32'h0;
      o_wb_sel   <= 4'h0;
      o_tx_data  <= 8'h0;
      o_tx_valid <= 1'b0;
      addr       <= 32'h0;
      frame      <= 40'h0;
      frame_len  <= 3'd0;
      byte_cnt   <= 3'd0;
`ifdef UART_WB_TIMEOUT_EN
      tmo_cnt    <= 16'h0;
`endif
    end else begin
      o_tx_valid <= 1'b0;
      if (i_cmd_stb && state != IDLE)
        o_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (i_cmd_stb) begin
            case (opcode)
              2'b00: addr <= payload;
              2'b01, 2'b10: begin
                o_wb_cyc <= 1'b1;
                o_wb_stb <= 1'b1;
                o_wb_we  <= (opcode == 2'b01);
                o_wb_sel <= 4'hF;
                if (opcode == 2'b01)
                  o_wb_data <= payload;
`ifdef UART_WB_TIMEOUT_EN
                tmo_cnt  <= 16'h0;
`endif
                state    <= BUS;
              end
              default: begin
                frame     <= {8'h45, 32'h0};
                frame_len <= 3'd1;
                byte_cnt  <= 3'd0;
                state     <= TX_LOAD;
              end
            endcase
          end
        end

        // Error outranks ack; a terminator also outranks a timeout on the same cycle.
        BUS: begin
          if (i_wb_err || i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_sel <= 4'h0;
            byte_cnt <= 3'd0;
            state    <= TX_LOAD;
            if (i_wb_err) begin
              frame     <= {8'h45, 32'h0};
              frame_len <= 3'd1;
            end else begin
              addr <= addr + 32'(AUTO_INC);
              if (o_wb_we) begin
                frame     <= {8'h4B, 32'h0};
                frame_len <= 3'd1;
              end else begin
                frame     <= {8'h52, i_wb_data};
                frame_len <= 3'd5;
              end
            end
          end
`ifdef UART_WB_TIMEOUT_EN
          else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_sel  <= 4'h0;
            frame     <= {8'h54, 32'h0};
            frame_len <= 3'd1;
            byte_cnt  <= 3'd0;
            state     <= TX_LOAD;
          end else begin
            tmo_cnt <= tmo_cnt + 16'h1;
          end
`endif
        end

        TX_LOAD: begin
          if (!i_tx_busy) begin
            o_tx_data  <= frame[39:32];
            o_tx_valid <= 1'b1;
            frame      <= {frame[31:0], 8'h0};
            byte_cnt   <= byte_cnt + 3'd1;
            state      <= TX_GAP;
          end
        end

        TX_GAP: state <= TX_WAIT;

        TX_WAIT: begin
          if (!i_tx_busy)
            state <= (byte_cnt == frame_len) ? IDLE : TX_LOAD;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: transaction-level model of address and response bytes,
// a transmitter model, and one per-cycle compare process.
module tb_uart_wb_master;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_stb;
  logic [33:0] i_cmd_word;
  logic        o_cmd_busy;
  logic        o_overrun;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_busy;

  int total = 0;
  int bad = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_log[$];
  logic [31:0] model_addr;
  logic [31:0] bus_addr_exp;
  logic [31:0] bus_data_exp;
  logic        bus_we_exp;
  logic        busy_hold = 1'b0;
  logic        loaded = 1'b0;
  logic        prev_valid = 1'b0;
  int          tx_cnt = 0;

  uart_wb_master #(
    .AUTO_INC(1'b1)
`ifdef UART_WB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_stb(i_cmd_stb), .i_cmd_word(i_cmd_word),
    .o_cmd_busy(o_cmd_busy), .o_overrun(o_overrun),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_busy(i_tx_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] rxAt(input int back);
    if (rx_log.size() > back) return rx_log[rx_log.size() - 1 - back];
    return 8'hxx;
  endfunction

  // Transmitter model: a load seen during a cycle makes busy rise just after the following edge.
  always @(negedge i_clk) loaded = o_tx_valid;
  always begin
    @(posedge i_clk);
    #1;
    if (tx_cnt > 0) tx_cnt--;
    if (loaded) tx_cnt = 3;
    i_tx_busy = (tx_cnt > 0) || busy_hold;
  end

  // Per-cycle compare against the model's expected bytes and bus contents.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_tx_valid) begin
        checkOutput("tx_valid_while_busy", i_tx_busy, 1'b0);
        checkOutput("tx_valid_width", prev_valid, 1'b0);
        checkOutput("tx_byte_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) checkOutput("tx_byte", o_tx_data, exp_q.pop_front());
        rx_log.push_back(o_tx_data);
      end
      if (o_wb_cyc) begin
        checkOutput("bus_stb_sel", {o_wb_stb, o_wb_sel}, 5'h1F);
        checkOutput("bus_we", o_wb_we, bus_we_exp);
        checkOutput("bus_addr", o_wb_addr, bus_addr_exp);
        if (bus_we_exp) checkOutput("bus_data", o_wb_data, bus_data_exp);
      end
    end
    prev_valid = i_reset ? 1'b0 : o_tx_valid;
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] pl);
    @(posedge i_clk); #1;
    i_cmd_stb  = 1'b1;
    i_cmd_word = {op, pl};
    @(posedge i_clk); #1;
    i_cmd_stb  = 1'b0;
  endtask

  task automatic doCmd(input logic [1:0] op, input logic [31:0] pl);
    case (op)
      2'b00: model_addr = pl;
      2'b01, 2'b10: begin
        bus_addr_exp = model_addr;
        bus_we_exp   = (op == 2'b01);
        if (op == 2'b01) bus_data_exp = pl;
      end
      default: exp_q.push_back(8'h45);
    endcase
    applyStimulus(op, pl);
  endtask

  task automatic waitCyc();
    for (int i = 0; i < 50; i++) begin
      if (o_wb_cyc) break;
      @(negedge i_clk);
    end
    if (!o_wb_cyc) checkOutput("wait_cyc_timeout", o_wb_cyc, 1'b1);
  endtask

  task automatic slaveRespond(input int delay, input logic ack, input logic err, input logic [31:0] rdata);
    logic [31:0] d;
    waitCyc();
    repeat (delay) @(posedge i_clk);
    @(posedge i_clk); #1;
    i_wb_ack  = ack;
    i_wb_err  = err;
    i_wb_data = rdata;
    @(posedge i_clk); #1;
    i_wb_ack  = 1'b0;
    i_wb_err  = 1'b0;
    i_wb_data = 32'h0;
    if (err) exp_q.push_back(8'h45);
    else if (bus_we_exp) exp_q.push_back(8'h4B);
    else begin
      exp_q.push_back(8'h52);
      d = rdata;
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(d[31:24]);
        d = d << 8;
      end
    end
    if (!err) model_addr = model_addr + 32'd1;
    @(negedge i_clk);
    checkOutput("cyc_drop", o_wb_cyc, 1'b0);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk); #1;
      if (!o_cmd_busy && exp_q.size() == 0) break;
    end
    checkOutput("busy_after_wait", o_cmd_busy, 1'b0);
    checkOutput("pending_bytes", exp_q.size(), 0);
    checkOutput("addr_model", o_wb_addr, model_addr);
  endtask

  task automatic resetNow(input string tag);
    #2 i_reset = 1'b1;
    #1;
    checkOutput({tag, "_addr_data"}, {o_wb_addr, o_wb_data}, 64'h0);
    checkOutput({tag, "_ctrl"}, {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_tx_data, o_tx_valid,
                                 o_cmd_busy, o_overrun}, 18'h0);
    exp_q.delete();
    model_addr = 32'h0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  initial begin
    int n0;
    int n;
    i_reset = 1'b0; i_cmd_stb = 1'b0; i_cmd_word = 34'h0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'h0;
    model_addr = 32'h0; bus_addr_exp = 32'h0; bus_data_exp = 32'h0; bus_we_exp = 1'b0;
    resetNow("reset_init");

    // SET_ADDR then WRITE with ack after 2 cycles
    doCmd(2'b00, 32'h0000_0010);
    @(negedge i_clk);
    checkOutput("setaddr_no_busy", o_cmd_busy, 1'b0);
    checkOutput("setaddr_addr", o_wb_addr, 32'h10);
    doCmd(2'b01, 32'hDEAD_BEEF);
    @(negedge i_clk);
    checkOutput("t1_cyc_stb_we", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b111);
    checkOutput("t1_addr_data", {o_wb_addr, o_wb_data}, 64'h0000_0010_DEAD_BEEF);
    slaveRespond(2, 1'b1, 1'b0, 32'h0);
    waitIdle();
    checkOutput("t1_byte", rxAt(0), 8'h4B);
    checkOutput("t1_addr", o_wb_addr, 32'h11);

    // READ accepted while the transmitter is still busy
    busy_hold = 1'b1;
    n0 = rx_log.size();
    doCmd(2'b10, 32'h0);
    slaveRespond(1, 1'b1, 1'b0, 32'h1234_5678);
    repeat (10) @(negedge i_clk);
    checkOutput("t2_held_while_busy", rx_log.size() - n0, 0);
    busy_hold = 1'b0;
    waitIdle();
    checkOutput("t2_count", rx_log.size() - n0, 5);
    checkOutput("t2_bytes", {rxAt(4), rxAt(3), rxAt(2), rxAt(1), rxAt(0)}, 40'h52_12_34_56_78);
    checkOutput("t2_addr", o_wb_addr, 32'h12);

    // ack and err together: err wins
    doCmd(2'b01, 32'hCAFE_0001);
    slaveRespond(0, 1'b1, 1'b1, 32'h0);
    waitIdle();
    checkOutput("t3_byte", rxAt(0), 8'h45);
    checkOutput("t3_addr", o_wb_addr, 32'h12);
    checkOutput("t3_overrun_clear", o_overrun, 1'b0);

    // reserved opcode
    doCmd(2'b11, 32'h0);
    waitIdle();
    checkOutput("rsv_byte", rxAt(0), 8'h45);

    // command strobe during BUS is dropped and flagged
    doCmd(2'b10, 32'h0);
    waitCyc();
    applyStimulus(2'b00, 32'h0000_0999);
    @(negedge i_clk);
    checkOutput("t4_overrun_set", o_overrun, 1'b1);
    checkOutput("t4_addr_kept", o_wb_addr, 32'h12);
    slaveRespond(1, 1'b1, 1'b0, 32'hA5A5_0F0F);
    waitIdle();
    checkOutput("t4_addr", o_wb_addr, 32'h13);
    checkOutput("t4_overrun_sticky", o_overrun, 1'b1);

`ifdef UART_WB_TIMEOUT_EN
    doCmd(2'b01, 32'h0000_1234);
    exp_q.push_back(8'h54);
    n = 0;
    @(negedge i_clk);
    while (o_wb_cyc && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    checkOutput("t5_timeout_len", n, 8);
    waitIdle();
    checkOutput("t5_byte", rxAt(0), 8'h54);
    checkOutput("t5_addr", o_wb_addr, 32'h13);
`else
    doCmd(2'b10, 32'h0);
    waitCyc();
    n = 0;
    repeat (1000) @(negedge i_clk);
    checkOutput("t5_still_cyc", o_wb_cyc, 1'b1);
    slaveRespond(0, 1'b1, 1'b0, 32'h0BAD_F00D);
    waitIdle();
    checkOutput("t5_addr", o_wb_addr, 32'h14);
`endif

    // reset during BUS
    doCmd(2'b01, 32'h5555_AAAA);
    waitCyc();
    @(negedge i_clk);
    resetNow("t6_bus");

    // reset during TX_WAIT of a read frame
    doCmd(2'b10, 32'h0);
    n0 = rx_log.size();
    slaveRespond(0, 1'b1, 1'b0, 32'h0102_0304);
    for (int i = 0; i < 100; i++) begin
      if (rx_log.size() > n0) break;
      @(negedge i_clk); #1;
    end
    repeat (2) @(negedge i_clk);
    resetNow("t6_txwait");
    repeat (30) @(negedge i_clk);
    checkOutput("t6_no_more_tx", rx_log.size() - n0, 1);

    // address wrap
    doCmd(2'b00, 32'hFFFF_FFFF);
    doCmd(2'b01, 32'h0000_0077);
    slaveRespond(0, 1'b1, 1'b0, 32'h0);
    waitIdle();
    checkOutput("wrap_addr", o_wb_addr, 32'h0);
    checkOutput("wrap_byte", rxAt(0), 8'h4B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
